fft_power_spectrum: RTL and testbench

Streaming stage directly downstream of the FFT core in the MFCC pipeline. It consumes FFT output bins as `complex` words (32-bit signed re/im), computes the power |X|² = re² + im² for each bin, and forwards only the one-sided spectrum (bins 0..FFT_SIZE/2) to the mel filterbank. Both sides use valid/ready handshakes. The block is a 2-stage stallable pipeline with a bin counter and optional frame-alignment checking.

---
 rtl/complex_pkg.sv | 30 +++
 rtl/complex_square_pipe.sv | 63 ++++++
 rtl/fft_power_spectrum.sv | 76 +++++++
 tb/tb_fft_power_spectrum.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// complex_pkg: complex sample type and power reference helpers shared by the MFCC pipeline
package complex_pkg;

   localparam int DATA_W  = 32;
   localparam int POWER_W = 64;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } complex;

   // Signed power with one guard bit, so re = im = -2^31 cannot wrap
   function automatic logic signed [POWER_W:0] c_power(input complex c);
      logic signed [POWER_W-1:0] a;
      logic signed [POWER_W-1:0] b;
      a = c.re;
      b = c.im;
      a = a * a;
      b = b * b;
      return {a[POWER_W-1], a} + {b[POWER_W-1], b};
   endfunction

   // Unsigned power; the sum never exceeds 2^63, so dropping the guard bit is lossless
   function automatic logic [POWER_W-1:0] c_power_u(input complex c);
      logic signed [POWER_W:0] p;
      p = c_power(c);
      return p[POWER_W-1:0];
   endfunction

endpackage

// File: rtl/complex_square_pipe.sv
// complex_square_pipe: two-stage |X|^2 pipeline with a common advance enable, multipliers isolated
module complex_square_pipe
   import complex_pkg::*;
#(
   parameter int TAG_W = 9
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_en,
   input  logic               i_valid,
   input  complex             i_data,
   input  logic [TAG_W-1:0]   i_bin,
   input  logic               i_last,
   output logic               o_valid,
   output logic [POWER_W-1:0] o_power,
   output logic [TAG_W-1:0]   o_bin,
   output logic               o_last
);

   logic signed [POWER_W-1:0] w_re;
   logic signed [POWER_W-1:0] w_im;
   logic signed [POWER_W-1:0] r_sq_re;
   logic signed [POWER_W-1:0] r_sq_im;
   logic                      r_valid1;
   logic [TAG_W-1:0]          r_bin1;
   logic                      r_last1;

   assign w_re = i_data.re;
   assign w_im = i_data.im;

   // Stage 1: square both components and carry the tags; bubbles shift like data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sq_re  <= '0;
         r_sq_im  <= '0;
         r_valid1 <= 1'b0;
         r_bin1   <= '0;
         r_last1  <= 1'b0;
      end else if (i_en) begin
         r_sq_re  <= w_re * w_re;
         r_sq_im  <= w_im * w_im;
         r_valid1 <= i_valid;
         r_bin1   <= i_bin;
         r_last1  <= i_last;
      end
   end

   // Stage 2: sum of squares, both terms <= 2^62 so the unsigned sum fits 64 bits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_power <= '0;
         o_valid <= 1'b0;
         o_bin   <= '0;
         o_last  <= 1'b0;
      end else if (i_en) begin
         o_power <= $unsigned(r_sq_re) + $unsigned(r_sq_im);
         o_valid <= r_valid1;
         o_bin   <= r_bin1;
         o_last  <= r_last1;
      end
   end

endmodule

// File: rtl/fft_power_spectrum.sv
// fft_power_spectrum: one-sided |X|^2 of streamed FFT bins; FFT_POWER_FRAME_CHECK_EN adds in_last alignment checking
module fft_power_spectrum
   import complex_pkg::*;
#(
   parameter int FFT_SIZE = 512,
   parameter int BIN_W    = $clog2(FFT_SIZE)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [63:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [POWER_W-1:0] out_power,
   output logic [BIN_W-1:0]   out_bin,
   output logic               out_last,
   output logic               frame_err
);

   localparam logic [BIN_W-1:0] HALF_BIN = BIN_W'(FFT_SIZE / 2);
   localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(FFT_SIZE - 1);

   logic             w_adv;
   logic             w_hs;
   logic             w_keep;
   logic [BIN_W-1:0] w_cnt_nxt;
   logic [BIN_W-1:0] r_bin_cnt;

   assign w_adv    = ~out_valid | out_ready;
   assign in_ready = w_adv;
   assign w_hs     = in_valid & w_adv;
   assign w_keep   = r_bin_cnt <= HALF_BIN;

`ifdef FFT_POWER_FRAME_CHECK_EN
   logic w_err_early;
   logic w_err_late;
   logic r_frame_err;

   assign w_err_early = w_hs & in_last & (r_bin_cnt != LAST_BIN);
   assign w_err_late  = w_hs & ~in_last & (r_bin_cnt == LAST_BIN);
   assign w_cnt_nxt   = w_err_early ? '0 : r_bin_cnt + BIN_W'(1);
   assign frame_err   = r_frame_err;

   // One-cycle pulse for an early or missing in_last
   always_ff @(posedge clk) begin
      if (!rst_n) r_frame_err <= 1'b0;
      else        r_frame_err <= w_err_early | w_err_late;
   end
`else
   assign w_cnt_nxt = r_bin_cnt + BIN_W'(1);
   assign frame_err = 1'b0 & in_last;
`endif

   // Bin counter advances on every accepted bin, wrapping by power-of-two overflow
   always_ff @(posedge clk) begin
      if (!rst_n)    r_bin_cnt <= '0;
      else if (w_hs) r_bin_cnt <= w_cnt_nxt;
   end

   complex_square_pipe #(.TAG_W(BIN_W)) u_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (w_adv),
      .i_valid (w_hs & w_keep),
      .i_data  (complex'(in_data)),
      .i_bin   (r_bin_cnt),
      .i_last  (r_bin_cnt == HALF_BIN),
      .o_valid (out_valid),
      .o_power (out_power),
      .o_bin   (out_bin),
      .o_last  (out_last)
   );

endmodule

// File: tb/tb_fft_power_spectrum.sv
// tb_fft_power_spectrum: table vectors, corner sequences and a random soak against a scoreboard
module tb_fft_power_spectrum;
   import complex_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [63:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [63:0] out_power;
   logic [2:0]  out_bin;
   logic        out_last;
   logic        frame_err;

   fft_power_spectrum #(.FFT_SIZE(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_power (out_power),
      .out_bin   (out_bin),
      .out_last  (out_last),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] p;
      logic [2:0]  b;
      logic        l;
   } out_t;

   typedef struct {
      logic [31:0] re;
      logic [31:0] im;
      logic [63:0] p;
      logic [2:0]  b;
      logic        l;
   } vec_t;

   out_t exp_q[$];
   out_t got_q[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   first_acc = -1;
   int   first_out = -1;
   bit   fe_on = 0;
   bit   rr_en = 0;
   logic [2:0] mcnt = '0;
   logic       m_ferr = 1'b0;
`ifdef FFT_POWER_FRAME_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic out_t got(input int i);
      return (got_q.size() > i) ? got_q[i] : '1;
   endfunction

   always @(posedge clk) cyc++;

   always @(posedge clk) if (rr_en) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
   end

   // Scoreboard: model the accepted bins, check every output handshake
   always @(negedge clk) begin
      out_t e;
      if (fe_on) chk("frame_err", {63'd0, frame_err}, {63'd0, m_ferr});
      if (!rst_n) begin
         exp_q.delete();
         mcnt = '0;
         m_ferr = 1'b0;
      end else begin
         if (out_valid && out_ready) begin
            got_q.push_back('{out_power, out_bin, out_last});
            if (first_out < 0) first_out = cyc;
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL sb_unexpected: got bin %0d power %h expected no output", out_bin, out_power);
            end else begin
               e = exp_q.pop_front();
               chk("sb_power", out_power, e.p);
               chk("sb_bin", {61'd0, out_bin}, {61'd0, e.b});
               chk("sb_last", {63'd0, out_last}, {63'd0, e.l});
            end
         end
         m_ferr = 1'b0;
         if (in_valid && in_ready) begin
            if (first_acc < 0) first_acc = cyc;
            if (mcnt <= 3'd4) exp_q.push_back('{c_power_u(complex'(in_data)), mcnt, mcnt == 3'd4});
            if (CHK_EN) begin
               m_ferr = (in_last != (mcnt == 3'd7));
               mcnt = (in_last && mcnt != 3'd7) ? 3'd0 : mcnt + 3'd1;
            end else begin
               mcnt = mcnt + 3'd1;
            end
         end
      end
   end

   task automatic do_reset();
      in_valid = 1'b0;
      in_last = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      fe_on = 1;
      got_q.delete();
      first_acc = -1;
      first_out = -1;
   endtask

   task automatic send(input logic [31:0] re, input logic [31:0] im, input logic last);
      int t = 0;
      in_valid = 1'b1;
      in_data = {re, im};
      in_last = last;
      @(negedge clk);
      while (!in_ready) begin
         if (++t > 200) begin
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready 0 for %0d cycles expected 1", t);
            $fatal(1, "stalled");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   vec_t tbl[5];
   logic [31:0] bp_re[8];
   logic [31:0] bp_im[8];
   logic [63:0] held;
   out_t g;

   initial begin
      tbl[0] = '{32'd0, 32'd0,  64'd0,  3'd0, 1'b0};
      tbl[1] = '{32'd1, -32'd1, 64'd2,  3'd1, 1'b0};
      tbl[2] = '{32'd2, -32'd2, 64'd8,  3'd2, 1'b0};
      tbl[3] = '{32'd3, -32'd3, 64'd18, 3'd3, 1'b0};
      tbl[4] = '{32'd4, -32'd4, 64'd32, 3'd4, 1'b1};

      // Reset state
      do_reset();
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_power", out_power, 64'd0);
      chk("rst_out_bin", {61'd0, out_bin}, 64'd0);
      chk("rst_out_last", {63'd0, out_last}, 64'd0);
      chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

      // One frame, bin k = {k, -k}
      for (int k = 0; k < 8; k++) send(32'(k), -32'(k), k == 7);
      idle(4);
      chk("frame_count", 64'(got_q.size()), 64'd5);
      for (int k = 0; k < 5; k++) begin
         g = got(k);
         chk("tbl_power", g.p, tbl[k].p);
         chk("tbl_bin", {61'd0, g.b}, {61'd0, tbl[k].b});
         chk("tbl_last", {63'd0, g.l}, {63'd0, tbl[k].l});
      end
      chk("latency", 64'(first_out - first_acc), 64'd2);

      // Extreme magnitude
      do_reset();
      send(32'h8000_0000, 32'h8000_0000, 1'b0);
      idle(4);
      chk("extreme_power", got(0).p, 64'h8000_0000_0000_0000);

      // Backpressure for 3 cycles mid-frame
      do_reset();
      for (int k = 0; k < 8; k++) begin
         bp_re[k] = $urandom;
         bp_im[k] = $urandom;
      end
      for (int k = 0; k < 3; k++) send(bp_re[k], bp_im[k], 1'b0);
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = {bp_re[3], bp_im[3]};
      held = out_power;
      chk("stall_first", held, c_power_u(complex'({bp_re[1], bp_im[1]})));
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
         chk("stall_valid", {63'd0, out_valid}, 64'd1);
         chk("stall_power", out_power, held);
         chk("stall_bin", {61'd0, out_bin}, 64'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      for (int k = 3; k < 8; k++) send(bp_re[k], bp_im[k], k == 7);
      idle(4);
      chk("stall_count", 64'(got_q.size()), 64'd5);
      chk("stall_drained", 64'(exp_q.size()), 64'd0);

      // Early in_last at bin 5, then one more bin
      do_reset();
      for (int k = 0; k < 5; k++) send(32'(k), 32'(k), 1'b0);
      send(32'd5, 32'd5, 1'b1);
      chk("early_err", {63'd0, frame_err}, {63'd0, CHK_EN});
      send(32'd6, 32'd7, 1'b0);
      idle(4);
      chk("early_count", 64'(got_q.size()), CHK_EN ? 64'd6 : 64'd5);
      if (got_q.size() == 6) begin
         g = got(5);
         chk("early_bin", {61'd0, g.b}, 64'd0);
         chk("early_power", g.p, 64'd85);
      end

      // Missing in_last on bin 7
      do_reset();
      for (int k = 0; k < 8; k++) send(32'(k), 32'd1, 1'b0);
      chk("late_err", {63'd0, frame_err}, {63'd0, CHK_EN});
      idle(3);

      // Reset with two bins in flight
      do_reset();
      send(32'd9, 32'd9, 1'b0);
      send(32'd8, 32'd8, 1'b0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      got_q.delete();
      chk("midrst_valid", {63'd0, out_valid}, 64'd0);
      chk("midrst_ready", {63'd0, in_ready}, 64'd1);
      send(32'd3, 32'd4, 1'b0);
      idle(4);
      chk("midrst_count", 64'(got_q.size()), 64'd1);
      chk("midrst_bin", {61'd0, got(0).b}, 64'd0);
      chk("midrst_power", got(0).p, 64'd25);

      // Random soak
      do_reset();
      rr_en = 1;
      for (int f = 0; f < 1000; f++) begin
         for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom,
                 ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom, k == 7);
         end
      end
      rr_en = 0;
      idle(1);
      out_ready = 1'b1;
      idle(5);
      chk("soak_drained", 64'(exp_q.size()), 64'd0);
      chk("soak_count", 64'(got_q.size()), 64'd5000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
